// File: rtl/seq_chunk_adder_ctrl.sv
// seq_chunk_adder_ctrl: multi-cycle add/subtract, one CHUNK-bit ripple slice per clock, LSB chunk first.
module seq_chunk_adder_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, msb_a_q, msb_a_d, msb_b_q, msb_b_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, work_q, work_d, eff_b;
  logic             done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CHUNK:0]   slice;
  assign eff_b = sub ? ~b : b;
  assign slice = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE) begin
      if (start) begin
        opa_d   = a;
        opb_d   = eff_b;
        carry_d = sub;
        cnt_d   = '0;
        msb_a_d = a[WIDTH-1];
        msb_b_d = eff_b[WIDTH-1];
        state_d = RUN;
      end
    end else begin
      // each slice result enters at the top, so after NCHUNK shifts chunk 0 sits at the bottom
      work_d  = (work_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
      opa_d   = opa_q >> CHUNK;
      opb_d   = opb_q >> CHUNK;
      carry_d = slice[CHUNK];
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(NCHUNK - 1)) begin
        sum_d   = work_d;
        cout_d  = slice[CHUNK];
        ovf_d   = (msb_a_q == msb_b_q) && (work_d[WIDTH-1] != msb_a_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder_ctrl.sv
// tb_seq_chunk_adder_ctrl: directed and random checks of the chunked add/subtract sequencer.
module tb_seq_chunk_adder_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic        busy, done, cout, overflow;
  int          vecs = 0, errs = 0, dcnt = 0, acc = 0;
  seq_chunk_adder_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) dcnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    start = 1'b1; a = ta; b = tb; sub = ts;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'b0;
    acc++;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask
  task automatic wait_done(input int n0, input logic [31:0] es, input logic ec, input logic eo);
    int n = n0;
    logic [31:0] prev = sum;
    while (n < 30) begin
      @(posedge clk); n++; #1;
      if (done === 1'b1) break;
      chk("sum_hold", sum, prev);
      chk("busy_run", 32'(busy), 32'd1);
    end
    chk("latency", 32'(n), 32'd9);
    chk("done", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sum", sum, es);
    chk("cout", 32'(cout), 32'(ec));
    chk("overflow", 32'(overflow), 32'(eo));
  endtask
  function automatic logic [33:0] ref_op(input logic [31:0] ra, input logic [31:0] rb, input logic rs);
    logic [31:0] eb = rs ? ~rb : rb;
    logic [32:0] r = {1'b0, ra} + {1'b0, eb} + 33'(rs);
    return {(ra[31] == eb[31]) && (r[31] != ra[31]), r};
  endfunction
  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [33:0] r;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    launch(32'h5, 32'h3, 1'b0);          wait_done(1, 32'h8, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("sum_held", sum, 32'h8);
    launch(32'hFFFFFFFF, 32'h1, 1'b0);   wait_done(1, 32'h0, 1'b1, 1'b0);
    launch(32'h7FFFFFFF, 32'h1, 1'b0);   wait_done(1, 32'h80000000, 1'b0, 1'b1);
    launch(32'h5, 32'h3, 1'b1);          wait_done(1, 32'h2, 1'b1, 1'b0);
    launch(32'h3, 32'h5, 1'b1);          wait_done(1, 32'hFFFFFFFE, 1'b0, 1'b0);
    launch(32'h80000000, 32'h1, 1'b1);   wait_done(1, 32'h7FFFFFFF, 1'b1, 1'b1);
    // start pulse while busy must not disturb the running operation
    launch(32'h10, 32'h20, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 32'hFFFF; b = 32'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, 32'h30, 1'b0, 1'b0);
    // back-to-back: new start in the done cycle
    launch(32'h7, 32'h8, 1'b0);          wait_done(1, 32'hF, 1'b0, 1'b0);
    // reset mid-run aborts without a done pulse; rst wins over start
    launch(32'h12345678, 32'h11111111, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    acc--;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    repeat (12) @(posedge clk);
    #1 chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    launch(32'h1, 32'h1, 1'b0);          wait_done(1, 32'h2, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      r = ref_op(ra, rb, rs);
      launch(ra, rb, rs);
      wait_done(1, r[31:0], r[32], r[33]);
    end
    @(posedge clk); @(negedge clk);
    chk("done_count", 32'(dcnt), 32'(acc));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
